nanorv32_regfile_sb: RTL and testbench

Parametrised successor to the core register file. It has configurable width and depth, two write ports and two asynchronous read ports. It adds optional write-to-read bypass, a hardware clear sequencer after reset, and a per-register pending-write scoreboard used by the decode stage to stall on outstanding load results. It sits between decode (read and scoreboard query), the ALU writeback (rd) and the load/micro-ROM writeback (rd2).

---
 rtl/nanorv32_regfile_sb_if.sv | 42 ++++
 rtl/nanorv32_regfile_sb.sv | 170 +++++++++++++++++
 tb/tb_nanorv32_regfile_sb.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_regfile_sb_if.sv
// Register-file access bundle: decode read/scoreboard query, two writeback ports, init status.
// Latency: pure signal bundle, no storage.
// Backpressure: none on the bus itself; init_busy tells the core to hold off.
interface nanorv32_regfile_sb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   // decode-side read ports
   logic [ADDR_WIDTH-1:0] sel_porta;
   logic [ADDR_WIDTH-1:0] sel_portb;
   logic [DATA_WIDTH-1:0] porta;
   logic [DATA_WIDTH-1:0] portb;
   // ALU writeback
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] rd;
   logic                  write_rd;
   // load / micro-ROM writeback
   logic [ADDR_WIDTH-1:0] sel_rd2;
   logic [DATA_WIDTH-1:0] rd2;
   logic                  write_rd2;
   // x0 as a hidden temporary for the micro-ROM
   logic                  allow_hidden_use_of_x0;
   // pending-write scoreboard
   logic                  pend_set;
   logic [ADDR_WIDTH-1:0] pend_sel;
   logic                  pend_a;
   logic                  pend_b;
   // clear sequencer status
   logic                  init_busy;

   modport master (
      output sel_porta, sel_portb, sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2,
             allow_hidden_use_of_x0, pend_set, pend_sel,
      input  porta, portb, pend_a, pend_b, init_busy
   );

   modport slave (
      input  sel_porta, sel_portb, sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2,
             allow_hidden_use_of_x0, pend_set, pend_sel,
      output porta, portb, pend_a, pend_b, init_busy
   );
endinterface

// File: rtl/nanorv32_regfile_sb.sv
// Parametrised 2W/2R register file with optional write bypass, post-reset clear sequencer and pending-write scoreboard.
// Latency: reads combinational (same-cycle forward when BYPASS=1); writes and scoreboard updates land on the rising edge.
// Backpressure: none; while init_busy is high all writes/pend sets are dropped and read outputs are forced to 0.
module nanorv32_regfile_sb #(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REGS       = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   nanorv32_regfile_sb_if.slave     bus
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(NUM_REGS - 1);
   localparam bit                    BYP         = (BYPASS != 0);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [ADDR_WIDTH-1:0] cnt_d;
   logic                  init_busy;

   logic [DATA_WIDTH-1:0] regfile [NUM_REGS];
   logic [NUM_REGS-1:0]   pend_q;
   logic [NUM_REGS-1:0]   pend_d;

   logic                  wr1_ok;
   logic                  wr2_ok;
   logic                  hit1_a;
   logic                  hit2_a;
   logic                  hit1_b;
   logic                  hit2_b;
   logic                  x0_blk_a;
   logic                  x0_blk_b;
   logic [DATA_WIDTH-1:0] porta_dat;
   logic [DATA_WIDTH-1:0] portb_dat;
   logic                  pend_a_dat;
   logic                  pend_b_dat;

   // Sequencer state and clear index; reset restarts the clear at index 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Sequencer next state: walk every index once, leave CLEAR on the edge that zeroes the last one
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign init_busy = (state_q == ST_CLEAR);

   // A write only counts when enabled, outside the clear window, and not aimed at a hidden x0
   assign wr1_ok = bus.write_rd  && !init_busy && ((bus.sel_rd  != '0) || bus.allow_hidden_use_of_x0);
   assign wr2_ok = bus.write_rd2 && !init_busy && ((bus.sel_rd2 != '0) || bus.allow_hidden_use_of_x0);

   // Array update: the sequencer owns the array while busy; otherwise rd2 then rd so rd wins a same-index clash
   always_ff @(posedge clk) begin
      if (init_busy) begin
         regfile[cnt_q] <= '0;
      end else begin
         if (wr2_ok && !(wr1_ok && (bus.sel_rd == bus.sel_rd2))) begin
            regfile[bus.sel_rd2] <= bus.rd2;
         end
         if (wr1_ok) begin
            regfile[bus.sel_rd] <= bus.rd;
         end
      end
   end

   // Scoreboard next value: writes retire pending entries, a new pend_set to the same index wins
   always_comb begin
      pend_d = pend_q;
      if (wr1_ok) begin
         pend_d[bus.sel_rd] = 1'b0;
      end
      if (wr2_ok) begin
         pend_d[bus.sel_rd2] = 1'b0;
      end
      if (bus.pend_set && !init_busy && (bus.pend_sel != '0)) begin
         pend_d[bus.pend_sel] = 1'b1;
      end
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Forwarding hits per read port; only meaningful when the bypass is built in
   assign hit1_a   = BYP && wr1_ok && (bus.sel_rd  == bus.sel_porta);
   assign hit2_a   = BYP && wr2_ok && (bus.sel_rd2 == bus.sel_porta);
   assign hit1_b   = BYP && wr1_ok && (bus.sel_rd  == bus.sel_portb);
   assign hit2_b   = BYP && wr2_ok && (bus.sel_rd2 == bus.sel_portb);
   assign x0_blk_a = (bus.sel_porta == '0) && !bus.allow_hidden_use_of_x0;
   assign x0_blk_b = (bus.sel_portb == '0) && !bus.allow_hidden_use_of_x0;

   // Port A: array read, forwarded write overrides (rd before rd2), then x0 / clear gating
   always_comb begin
      porta_dat  = regfile[bus.sel_porta];
      pend_a_dat = pend_q[bus.sel_porta];
      if (hit1_a) begin
         porta_dat  = bus.rd;
         pend_a_dat = 1'b0;
      end else if (hit2_a) begin
         porta_dat  = bus.rd2;
         pend_a_dat = 1'b0;
      end
      if (init_busy || x0_blk_a) begin
         porta_dat  = '0;
         pend_a_dat = 1'b0;
      end
   end

   // Port B: same structure as port A
   always_comb begin
      portb_dat  = regfile[bus.sel_portb];
      pend_b_dat = pend_q[bus.sel_portb];
      if (hit1_b) begin
         portb_dat  = bus.rd;
         pend_b_dat = 1'b0;
      end else if (hit2_b) begin
         portb_dat  = bus.rd2;
         pend_b_dat = 1'b0;
      end
      if (init_busy || x0_blk_b) begin
         portb_dat  = '0;
         pend_b_dat = 1'b0;
      end
   end

   assign bus.porta     = porta_dat;
   assign bus.portb     = portb_dat;
   assign bus.pend_a    = pend_a_dat;
   assign bus.pend_b    = pend_b_dat;
   assign bus.init_busy = init_busy;

endmodule

// File: tb/tb_nanorv32_regfile_sb.sv
// Bench for nanorv32_regfile_sb: four configurations driven by one stimulus stream and checked against a table model.
// Latency: model predicts combinational outputs each cycle and commits state on the rising edge.
// Backpressure: stimulus keeps running through clear windows; the model expects those writes to be dropped.
module tb_nanorv32_regfile_sb;

   localparam int NK = 4;

   logic clk;
   logic rst;

   nanorv32_regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_a ();
   nanorv32_regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_b ();
   nanorv32_regfile_sb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) if_c ();
   nanorv32_regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) if_d ();

   nanorv32_regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .BYPASS(1), .CLEAR_ON_RESET(1))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   nanorv32_regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .BYPASS(0), .CLEAR_ON_RESET(1))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));
   nanorv32_regfile_sb #(.DATA_WIDTH(64), .NUM_REGS(16), .ADDR_WIDTH(4), .BYPASS(1), .CLEAR_ON_RESET(1))
      dut_c (.clk(clk), .rst(rst), .bus(if_c));
   nanorv32_regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .BYPASS(0), .CLEAR_ON_RESET(0))
      dut_d (.clk(clk), .rst(rst), .bus(if_d));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // shared stimulus
   logic        r;
   logic [4:0]  s_a, s_b, s_rd, s_rd2, s_ps;
   logic [63:0] d1, d2;
   logic        w1, w2, al, ps;

   // reference model state
   logic [63:0] m_mem   [NK][32];
   bit          m_known [NK][32];
   bit          m_pend  [NK][32];
   int          m_left  [NK];

   // observations from the most recent cycle
   logic [63:0] last_a  [NK];
   logic [63:0] last_b  [NK];
   logic        last_pa [NK];
   logic        last_pb [NK];
   int          busy_cnt[NK];

   int n_chk;
   int n_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nregs(input int k);
      return (k == 2) ? 16 : 32;
   endfunction

   function automatic bit byp(input int k);
      return (k == 0) || (k == 2);
   endfunction

   function automatic bit clr(input int k);
      return k != 3;
   endfunction

   function automatic logic [63:0] dmask(input int k);
      return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic int idx(input int k, input logic [4:0] s);
      return int'(s) & (nregs(k) - 1);
   endfunction

   function automatic bit m_busy(input int k);
      return r ? clr(k) : (m_left[k] > 0);
   endfunction

   function automatic bit v1(input int k);
      return w1 && !m_busy(k) && ((idx(k, s_rd) != 0) || al);
   endfunction

   function automatic bit v2(input int k);
      return w2 && !m_busy(k) && ((idx(k, s_rd2) != 0) || al);
   endfunction

   // Expected read data, whether that data is defined, and expected pending flag
   task automatic m_read(input int k, input logic [4:0] s, output logic [63:0] dat, output bit kn, output bit pnd);
      int i;
      i   = idx(k, s);
      dat = 64'h0;
      kn  = 1'b1;
      pnd = 1'b0;
      if (r) begin
         kn = clr(k);
      end else if (m_busy(k) || (i == 0 && !al)) begin
         kn = 1'b1;
      end else if (byp(k) && v1(k) && idx(k, s_rd) == i) begin
         dat = d1 & dmask(k);
      end else if (byp(k) && v2(k) && idx(k, s_rd2) == i) begin
         dat = d2 & dmask(k);
      end else begin
         dat = m_mem[k][i];
         kn  = m_known[k][i];
         pnd = m_pend[k][i];
      end
   endtask

   task automatic m_update();
      for (int k = 0; k < NK; k++) begin
         if (r) begin
            for (int i = 0; i < 32; i++) m_pend[k][i] = 1'b0;
            m_left[k] = clr(k) ? nregs(k) : 0;
         end else if (m_left[k] > 0) begin
            m_mem[k][nregs(k) - m_left[k]]   = 64'h0;
            m_known[k][nregs(k) - m_left[k]] = 1'b1;
            m_left[k]--;
         end else begin
            if (v2(k)) begin
               m_mem[k][idx(k, s_rd2)]   = d2 & dmask(k);
               m_known[k][idx(k, s_rd2)] = 1'b1;
               m_pend[k][idx(k, s_rd2)]  = 1'b0;
            end
            if (v1(k)) begin
               m_mem[k][idx(k, s_rd)]   = d1 & dmask(k);
               m_known[k][idx(k, s_rd)] = 1'b1;
               m_pend[k][idx(k, s_rd)]  = 1'b0;
            end
            if (ps && idx(k, s_ps) != 0) m_pend[k][idx(k, s_ps)] = 1'b1;
         end
      end
   endtask

   task automatic drive_all();
      rst = r;
      if_a.sel_porta = s_a;      if_a.sel_portb = s_b;      if_a.sel_rd = s_rd;      if_a.sel_rd2 = s_rd2;
      if_a.rd = d1[31:0];        if_a.rd2 = d2[31:0];       if_a.write_rd = w1;      if_a.write_rd2 = w2;
      if_a.allow_hidden_use_of_x0 = al;  if_a.pend_set = ps;  if_a.pend_sel = s_ps;
      if_b.sel_porta = s_a;      if_b.sel_portb = s_b;      if_b.sel_rd = s_rd;      if_b.sel_rd2 = s_rd2;
      if_b.rd = d1[31:0];        if_b.rd2 = d2[31:0];       if_b.write_rd = w1;      if_b.write_rd2 = w2;
      if_b.allow_hidden_use_of_x0 = al;  if_b.pend_set = ps;  if_b.pend_sel = s_ps;
      if_c.sel_porta = s_a[3:0]; if_c.sel_portb = s_b[3:0]; if_c.sel_rd = s_rd[3:0]; if_c.sel_rd2 = s_rd2[3:0];
      if_c.rd = d1;              if_c.rd2 = d2;             if_c.write_rd = w1;      if_c.write_rd2 = w2;
      if_c.allow_hidden_use_of_x0 = al;  if_c.pend_set = ps;  if_c.pend_sel = s_ps[3:0];
      if_d.sel_porta = s_a;      if_d.sel_portb = s_b;      if_d.sel_rd = s_rd;      if_d.sel_rd2 = s_rd2;
      if_d.rd = d1[31:0];        if_d.rd2 = d2[31:0];       if_d.write_rd = w1;      if_d.write_rd2 = w2;
      if_d.allow_hidden_use_of_x0 = al;  if_d.pend_set = ps;  if_d.pend_sel = s_ps;
   endtask

   task automatic observe(input int k, output logic [63:0] pa, output logic [63:0] pb,
                          output logic qa, output logic qb, output logic bz);
      case (k)
         0: begin pa = {32'h0, if_a.porta}; pb = {32'h0, if_a.portb}; qa = if_a.pend_a; qb = if_a.pend_b; bz = if_a.init_busy; end
         1: begin pa = {32'h0, if_b.porta}; pb = {32'h0, if_b.portb}; qa = if_b.pend_a; qb = if_b.pend_b; bz = if_b.init_busy; end
         2: begin pa = if_c.porta;          pb = if_c.portb;          qa = if_c.pend_a; qb = if_c.pend_b; bz = if_c.init_busy; end
         default: begin pa = {32'h0, if_d.porta}; pb = {32'h0, if_d.portb}; qa = if_d.pend_a; qb = if_d.pend_b; bz = if_d.init_busy; end
      endcase
   endtask

   // One clock: drive at the falling edge, check just after, commit the model at the rising edge
   task automatic tick();
      logic [63:0] ea, eb, oa, ob;
      bit          ka, kb, pa, pb;
      logic        qa, qb, bz;
      @(negedge clk);
      drive_all();
      #2;
      for (int k = 0; k < NK; k++) begin
         m_read(k, s_a, ea, ka, pa);
         m_read(k, s_b, eb, kb, pb);
         observe(k, oa, ob, qa, qb, bz);
         check($sformatf("init_busy[%0d]", k), {63'h0, bz}, {63'h0, m_busy(k)});
         check($sformatf("pend_a[%0d]", k), {63'h0, qa}, {63'h0, pa});
         check($sformatf("pend_b[%0d]", k), {63'h0, qb}, {63'h0, pb});
         if (ka) check($sformatf("porta[%0d]", k), oa, ea);
         if (kb) check($sformatf("portb[%0d]", k), ob, eb);
         if (bz === 1'b1) busy_cnt[k]++;
         last_a[k]  = oa;
         last_b[k]  = ob;
         last_pa[k] = qa;
         last_pb[k] = qb;
      end
      @(posedge clk);
      m_update();
   endtask

   task automatic idle();
      w1 = 1'b0; w2 = 1'b0; ps = 1'b0; al = 1'b0;
      s_a = '0; s_b = '0; s_rd = '0; s_rd2 = '0; s_ps = '0;
      d1 = '0; d2 = '0;
   endtask

   task automatic clr_cnt();
      for (int k = 0; k < NK; k++) busy_cnt[k] = 0;
   endtask

   function automatic logic [4:0] rnd_idx();
      case ($urandom_range(0, 4))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd9;
         3: return 5'd17;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      n_chk = 0;
      n_err = 0;
      for (int k = 0; k < NK; k++) begin
         m_left[k] = 0;
         for (int i = 0; i < 32; i++) begin
            m_mem[k][i] = 64'h0; m_known[k][i] = 1'b0; m_pend[k][i] = 1'b0;
         end
      end
      clr_cnt();
      r = 1'b1;
      idle();
      drive_all();

      // reset, then a clear window with an ALU write to x5 that must be swallowed
      tick(); tick();
      r = 1'b0;
      clr_cnt();
      w1 = 1'b1; s_rd = 5'd5; d1 = 64'h1234_5678;
      repeat (30) tick();
      w1 = 1'b0;
      repeat (4) tick();
      check("clear_len_32", 64'(busy_cnt[0]), 64'd32);
      check("clear_len_nobyp", 64'(busy_cnt[1]), 64'd32);
      check("clear_len_16", 64'(busy_cnt[2]), 64'd16);
      check("no_clear_len", 64'(busy_cnt[3]), 64'd0);
      for (int i = 0; i < 32; i++) begin
         s_a = 5'(i);
         tick();
         check("clear_zero", last_a[0], 64'h0);
      end

      // reset again part-way through the window: it restarts from scratch
      r = 1'b1; tick(); r = 1'b0;
      repeat (10) tick();
      r = 1'b1; tick(); r = 1'b0;
      clr_cnt();
      repeat (34) tick();
      check("clear_restart_len", 64'(busy_cnt[0]), 64'd32);

      // x0 gating
      idle();
      w1 = 1'b1; s_rd = 5'd0; d1 = 64'hDEAD_BEEF; tick();
      w1 = 1'b0; tick();
      check("x0_blocked", last_a[0], 64'h0);
      al = 1'b1; w1 = 1'b1; tick();
      w1 = 1'b0; tick();
      check("x0_allowed", last_a[0], 64'hDEAD_BEEF);
      al = 1'b0; tick();
      check("x0_dropped", last_a[0], 64'h0);

      // dual-write conflict, then two different targets
      w1 = 1'b1; s_rd = 5'd7; d1 = 64'h11; w2 = 1'b1; s_rd2 = 5'd7; d2 = 64'h22; tick();
      w1 = 1'b0; w2 = 1'b0; s_a = 5'd7; tick();
      check("dual_rd_wins", last_a[0], 64'h11);
      check("dual_rd_wins_nobyp", last_a[1], 64'h11);
      w1 = 1'b1; s_rd = 5'd7; d1 = 64'h33; w2 = 1'b1; s_rd2 = 5'd8; d2 = 64'h44; tick();
      w1 = 1'b0; w2 = 1'b0; s_a = 5'd7; s_b = 5'd8; tick();
      check("dual_x7", last_a[0], 64'h33);
      check("dual_x8", last_b[0], 64'h44);

      // bypass on/off
      s_a = 5'd3; w1 = 1'b1; s_rd = 5'd3; d1 = 64'hA5A5_A5A5; tick();
      check("bypass_on", last_a[0], 64'hA5A5_A5A5);
      check("bypass_off_old", last_a[1], 64'h0);
      w1 = 1'b0; tick();
      check("bypass_off_next", last_a[1], 64'hA5A5_A5A5);

      // scoreboard
      ps = 1'b1; s_ps = 5'd9; s_a = 5'd9; tick();
      ps = 1'b0; tick();
      check("pend_set", {63'h0, last_pa[0]}, 64'd1);
      check("pend_set_nobyp", {63'h0, last_pa[1]}, 64'd1);
      w2 = 1'b1; s_rd2 = 5'd9; d2 = 64'h99; tick();
      check("pend_clr_byp_same", {63'h0, last_pa[0]}, 64'd0);
      check("pend_clr_nobyp_same", {63'h0, last_pa[1]}, 64'd1);
      w2 = 1'b0; tick();
      check("pend_clr_nobyp_next", {63'h0, last_pa[1]}, 64'd0);
      ps = 1'b1; s_ps = 5'd9; w1 = 1'b1; s_rd = 5'd9; d1 = 64'h5; tick();
      ps = 1'b0; w1 = 1'b0; tick();
      check("pend_set_wins", {63'h0, last_pa[0]}, 64'd1);
      al = 1'b1; ps = 1'b1; s_ps = 5'd0; s_a = 5'd0; tick();
      ps = 1'b0; tick();
      check("pend_x0_ignored", {63'h0, last_pa[0]}, 64'd0);
      al = 1'b0;

      // 64-bit / 16-entry round trip through x15
      w1 = 1'b1; s_rd = 5'd15; d1 = 64'hFEDC_BA98_7654_3210; tick();
      w1 = 1'b0; s_a = 5'd15; tick();
      check("wide_roundtrip", last_a[2], 64'hFEDC_BA98_7654_3210);
      check("narrow_roundtrip", last_a[0], 64'h7654_3210);

      // randomized traffic with occasional resets
      repeat (3000) begin
         r     = ($urandom_range(0, 499) == 0);
         s_a   = rnd_idx();
         s_b   = rnd_idx();
         s_rd  = rnd_idx();
         s_rd2 = rnd_idx();
         s_ps  = rnd_idx();
         d1    = {$urandom, $urandom};
         d2    = {$urandom, $urandom};
         al    = ($urandom_range(0, 9) == 0);
         w1    = !r && ($urandom_range(0, 1) == 1);
         w2    = !r && ($urandom_range(0, 1) == 1);
         ps    = !r && ($urandom_range(0, 9) < 3);
         tick();
      end
      r = 1'b0;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
